pblaze_io_intc: RTL

Parametrised PicoBlaze (KCPSM6) register interface for the Nexys4 designs. It adds configurable input and output port counts, readback of output registers, and per-port read/write strobes for downstream handshakes. It also contains a multi-source interrupt controller with synchronisers, per-source edge/level mode, a mask and W1C pending bits, driving the closed-loop interrupt/interrupt_ack pair.

---
 rtl/pblaze_io_intc.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pblaze_io_intc.sv
// PicoBlaze (KCPSM6) I/O register block with a multi-source interrupt controller.
// Includes input ports with read pulses and output registers with readback and
// write pulses. Interrupt sources pass through synchronisers and then set W1C
// pending bits (edge or level per source). The pending bits are masked and
// drive a closed-loop interrupt/interrupt_ack FSM.
//
// Handshake: the PicoBlaze side has no back-pressure. A qualified access is
// write_strobe/read_strobe high with port_id valid, and it completes on that
// clock edge. io_data_out is always the registered decode of the previous
// cycle's port_id.
module pblaze_io_intc #(
    parameter int          NUM_IN        = 4,
    parameter int          NUM_OUT       = 4,
    parameter int          NUM_IRQ       = 4,
    parameter logic [7:0]  OUT_RESET_VAL = 8'h00
) (
    input  logic                 sysclk,
    input  logic                 sysreset,
    input  logic                 write_strobe,
    input  logic                 read_strobe,
    input  logic [7:0]           port_id,
    input  logic [7:0]           io_data_in,
    output logic [7:0]           io_data_out,
    input  logic                 interrupt_ack,
    output logic                 interrupt,
    input  logic [NUM_IN*8-1:0]  in_ports,
    output logic [NUM_IN-1:0]    in_rd,
    output logic [NUM_OUT*8-1:0] out_ports,
    output logic [NUM_OUT-1:0]   out_wr,
    input  logic [NUM_IRQ-1:0]   irq_in,
    output logic [1:0]           irq_state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    irq_state_e           state_q;
    logic                 interrupt_q;

    logic [7:0]           rdata_d, rdata_q;
    logic [NUM_IN-1:0]    in_rd_d, in_rd_q;
    logic [NUM_OUT*8-1:0] out_ports_d, out_ports_q;
    logic [NUM_OUT-1:0]   out_wr_d, out_wr_q;
    logic [NUM_IRQ-1:0]   mask_d, mask_q;
    logic [NUM_IRQ-1:0]   mode_d, mode_q;
    logic [NUM_IRQ-1:0]   pend_d, pend_q;
    logic [NUM_IRQ-1:0]   s1_q, s2_q, prev_q;
    logic [NUM_IRQ-1:0]   set_v;
    logic [NUM_IRQ-1:0]   clr_v;
    logic                 wr_pend;
    logic [7:0]           pend8, mask8, mode8, raw8;

    assign wr_pend = write_strobe && (port_id == 8'h20);

    // Output registers and their write pulses, plus input-port read pulses.
    always_comb begin
        out_ports_d = out_ports_q;
        out_wr_d    = '0;
        in_rd_d     = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (write_strobe && (port_id == 8'(16 + k))) begin
                out_ports_d[k*8 +: 8] = io_data_in;
                out_wr_d[k]           = 1'b1;
            end
        end
        for (int k = 0; k < NUM_IN; k++) begin
            in_rd_d[k] = read_strobe && (port_id == 8'(k));
        end
    end

    // IRQ mask/mode writes and pending update (set beats a same-cycle W1C).
    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        if (write_strobe && (port_id == 8'h21)) mask_d = io_data_in[NUM_IRQ-1:0];
        if (write_strobe && (port_id == 8'h23)) mode_d = io_data_in[NUM_IRQ-1:0];
        set_v  = (mode_q & s2_q & ~prev_q) | (~mode_q & s2_q);
        clr_v  = wr_pend ? io_data_in[NUM_IRQ-1:0] : '0;
        pend_d = (pend_q & ~clr_v) | set_v;
    end

    // Read-data decode; unmapped addresses and unused IRQ bits read zero.
    always_comb begin
        pend8 = '0;
        mask8 = '0;
        mode8 = '0;
        raw8  = '0;
        pend8[NUM_IRQ-1:0] = pend_q;
        mask8[NUM_IRQ-1:0] = mask_q;
        mode8[NUM_IRQ-1:0] = mode_q;
        raw8[NUM_IRQ-1:0]  = s2_q;
        rdata_d = 8'h00;
        for (int k = 0; k < NUM_IN; k++) begin
            if (port_id == 8'(k)) rdata_d = in_ports[k*8 +: 8];
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            if (port_id == 8'(16 + k)) rdata_d = out_ports_q[k*8 +: 8];
        end
        case (port_id)
            8'h20:   rdata_d = pend8;
            8'h21:   rdata_d = mask8;
            8'h22:   rdata_d = raw8;
            8'h23:   rdata_d = mode8;
            default: ;
        endcase
    end

    // Register file, synchronisers and pending bits.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            rdata_q     <= '0;
            in_rd_q     <= '0;
            out_ports_q <= {NUM_OUT{OUT_RESET_VAL}};
            out_wr_q    <= '0;
            mask_q      <= '0;
            mode_q      <= '0;
            pend_q      <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            prev_q      <= '0;
        end else begin
            rdata_q     <= rdata_d;
            in_rd_q     <= in_rd_d;
            out_ports_q <= out_ports_d;
            out_wr_q    <= out_wr_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            s1_q        <= irq_in;
            s2_q        <= s1_q;
            prev_q      <= s2_q;
        end
    end

    // Interrupt FSM: request held until acked, re-armed by any write to IRQ_PEND.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q     <= ST_IDLE;
            interrupt_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|(pend_q & mask_q)) begin
                        state_q     <= ST_ASSERT;
                        interrupt_q <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (interrupt_ack) begin
                        state_q     <= ST_SERVICE;
                        interrupt_q <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (wr_pend) state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    interrupt_q <= 1'b0;
                end
            endcase
        end
    end

    assign io_data_out   = rdata_q;
    assign in_rd         = in_rd_q;
    assign out_ports     = out_ports_q;
    assign out_wr        = out_wr_q;
    assign interrupt     = interrupt_q;
    assign irq_state_dbg = state_q;

endmodule
